// File: rtl/ldl_fifo_pkg.sv
// Shared definitions for both endpoints of the async FIFO.
// Pointers are AW+1 bits wide. The extra top bit tells a full RAM apart from an empty one.
package ldl_fifo_pkg;

    localparam int OCC_MAX = 2;

    function automatic logic [31:0] ptr_mask(input int aw);
        return (32'd1 << (aw + 1)) - 32'd1;
    endfunction

    function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input int aw);
        return (ptr + 32'd1) & ptr_mask(aw);
    endfunction

    // Gives a - b modulo 2^(aw+1): the number of words between two pointers.
    function automatic logic [31:0] ptr_diff(input logic [31:0] a, input logic [31:0] b,
                                             input int aw);
        return (a - b) & ptr_mask(aw);
    endfunction

endpackage

// File: rtl/ldl_fifo_rd_stream_skid.sv
// Two-entry register FIFO for prefetched RAM words.
// The head entry drives the output stream directly.
module ldl_skid_buf2 #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [1:0]    occ,
    output logic [DW-1:0] head
);
    logic [DW-1:0] mem_q [2];
    logic          wr_q;
    logic          rd_q;
    logic [1:0]    occ_q;
    logic          pop_ok;
    logic          push_ok;
    logic [1:0]    we;

    assign pop_ok  = pop && (occ_q != 2'd0);
    assign push_ok = push && ((occ_q != 2'd2) || pop_ok);

    for (genvar gi = 0; gi < 2; gi++) begin : g_we
        assign we[gi] = push_ok && (wr_q == 1'(gi));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            occ_q <= 2'd0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (we[i]) mem_q[i] <= din;
            end
            wr_q  <= wr_q ^ push_ok;
            rd_q  <= rd_q ^ pop_ok;
            occ_q <= occ_q + 2'(push_ok) - 2'(pop_ok);
        end
    end

    assign occ  = occ_q;
    assign head = mem_q[rd_q];

endmodule

// File: rtl/ldl_fifo_rd_stream.sv
// Read-side endpoint of the async FIFO. It issues RAM reads ahead of the consumer into a 2-entry buffer.
// It publishes the read pointer so the write side can see freed space.
module ldl_fifo_rd_stream
    import ldl_fifo_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW:0]   w_pt,
    output logic [AW:0]   r_pt,
    output logic          mr,
    output logic [AW-1:0] ra,
    input  logic [DW-1:0] mem_dout,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic [AW:0]   rcnt,
    output logic [AW+1:0] level,
    output logic          err
);
    localparam logic [AW+1:0] DEPTH = (AW+2)'(1) << AW;

    logic [AW:0]   r_pt_q, r_pt_d;
    logic          infl_q;
    logic          err_q, err_d;
    logic [1:0]    occ;
    logic          pop;
    logic          mem_empty;
    logic [2:0]    demand;

    assign pop       = m_valid && m_ready;
    assign mem_empty = (w_pt == r_pt_q);

    // This counts the words the buffer will hold after this edge if no new read is issued.
    // A read is issued only while that count leaves room for the word it returns.
    assign demand = 3'(occ) + 3'(infl_q) - 3'(pop);
    assign mr     = !rst && !mem_empty && (demand < 3'(OCC_MAX));

    assign r_pt_d = mr ? (AW+1)'(ptr_inc(32'(r_pt_q), AW)) : r_pt_q;
    assign rcnt   = (AW+1)'(ptr_diff(32'(w_pt), 32'(r_pt_q), AW));
    assign err_d  = err_q || ({1'b0, rcnt} > DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pt_q <= '0;
            infl_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            r_pt_q <= r_pt_d;
            infl_q <= mr;
            err_q  <= err_d;
        end
    end

    ldl_skid_buf2 #(.DW(DW)) u_buf (
        .clk  (clk),
        .rst  (rst),
        .push (infl_q),
        .din  (mem_dout),
        .pop  (pop),
        .occ  (occ),
        .head (m_data)
    );

    assign m_valid = (occ != 2'd0);
    assign r_pt    = r_pt_q;
    assign ra      = r_pt_q[AW-1:0];
    assign level   = (AW+2)'(rcnt) + (AW+2)'(occ) + (AW+2)'(infl_q);
    assign err     = err_q;

endmodule

// File: tb/tb_ldl_fifo_rd_stream.sv
// Self-checking bench for ldl_fifo_rd_stream with AW=3.
// The bench models the RAM and the write side, and keeps a queue of expected words.
module tb_ldl_fifo_rd_stream;
    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW:0]   w_pt;
    logic [AW:0]   r_pt;
    logic          mr;
    logic [AW-1:0] ra;
    logic [DW-1:0] mem_dout = '0;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [AW:0]   rcnt;
    logic [AW+1:0] level;
    logic          err;

    ldl_fifo_rd_stream #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .w_pt(w_pt), .r_pt(r_pt), .mr(mr), .ra(ra),
        .mem_dout(mem_dout), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .rcnt(rcnt), .level(level), .err(err)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk) if (mr) mem_dout <= ram[ra];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; w_pt = '0; m_ready = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [AW:0]   w;
        logic          rdy;
        logic          mr;
        logic [AW-1:0] ra;
        logic          vld;
        logic [DW-1:0] data;
        logic [AW:0]   rpt;
        logic [AW+1:0] lvl;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt, idx, written, received;
        logic [AW:0] wp;
        logic [DW-1:0] q [$];
        logic [DW-1:0] exp_d;
        int st;

        vecs[0] = '{w:4'd1, rdy:1'b1, mr:1'b1, ra:3'd0, vld:1'b0, data:8'h00, rpt:4'd0, lvl:5'd1};
        vecs[1] = '{w:4'd1, rdy:1'b1, mr:1'b0, ra:3'd1, vld:1'b0, data:8'h00, rpt:4'd1, lvl:5'd1};
        vecs[2] = '{w:4'd1, rdy:1'b1, mr:1'b0, ra:3'd1, vld:1'b1, data:8'hA5, rpt:4'd1, lvl:5'd1};
        vecs[3] = '{w:4'd1, rdy:1'b1, mr:1'b0, ra:3'd1, vld:1'b0, data:8'h00, rpt:4'd1, lvl:5'd0};
        for (int i = 0; i < DEPTH; i++) ram[i] = '0;

        // Test 1: reset values, then an empty FIFO must issue no reads.
        rst = 1'b1; w_pt = '0; m_ready = 1'b0;
        step(); step(); #4;
        check("rst_mr", 32'(mr), 0);
        check("rst_valid", 32'(m_valid), 0);
        check("rst_data", 32'(m_data), 0);
        check("rst_rpt", 32'(r_pt), 0);
        check("rst_level", 32'(level), 0);
        check("rst_err", 32'(err), 0);
        step();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #4;
            check("idle_mr", 32'(mr), 0);
            step();
        end

        // Test 2: one word, table-driven cycle by cycle.
        ram[0] = 8'hA5;
        for (int i = 0; i < 4; i++) begin
            w_pt = vecs[i].w; m_ready = vecs[i].rdy;
            #4;
            check($sformatf("v%0d_mr", i), 32'(mr), 32'(vecs[i].mr));
            if (vecs[i].mr) check($sformatf("v%0d_ra", i), 32'(ra), 32'(vecs[i].ra));
            check($sformatf("v%0d_valid", i), 32'(m_valid), 32'(vecs[i].vld));
            if (vecs[i].vld) check($sformatf("v%0d_data", i), 32'(m_data), 32'(vecs[i].data));
            check($sformatf("v%0d_rpt", i), 32'(r_pt), 32'(vecs[i].rpt));
            check($sformatf("v%0d_level", i), 32'(level), 32'(vecs[i].lvl));
            $display("tx vec %0d: mr=%0b valid=%0b data=%02h r_pt=%0d level=%0d",
                     i, mr, m_valid, m_data, r_pt, level);
            step();
        end

        // Test 3: the pointer jumps by a full RAM. Expect eight back-to-back beats.
        do_reset();
        for (int i = 0; i < DEPTH; i++) ram[i] = 8'($urandom);
        step();
        w_pt = 4'd8; m_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            #4;
            check($sformatf("burst_valid_c%0d", k), 32'(m_valid), 32'((k >= 2 && k <= 9) ? 1 : 0));
            if (k >= 2 && k <= 9) begin
                check($sformatf("burst_data_c%0d", k), 32'(m_data), 32'(ram[k-2]));
                $display("tx burst beat %0d data=%02h", k - 2, m_data);
            end
            check($sformatf("burst_rcnt_c%0d", k), 32'(rcnt), 32'((k < 8) ? 8 - k : 0));
            step();
        end

        // Test 4: under backpressure the endpoint reads exactly two words ahead.
        do_reset();
        for (int i = 0; i < 5; i++) ram[i] = 8'($urandom);
        step();
        w_pt = 4'd5; m_ready = 1'b0; cnt = 0;
        for (int k = 0; k < 8; k++) begin
            #4;
            if (mr) cnt++;
            if (k >= 3) begin
                check("bp_valid", 32'(m_valid), 1);
                check("bp_data_stable", 32'(m_data), 32'(ram[0]));
            end
            step();
        end
        #4;
        check("bp_mr_pulses", 32'(cnt), 2);
        check("bp_rpt", 32'(r_pt), 2);
        check("bp_rcnt", 32'(rcnt), 3);
        check("bp_level", 32'(level), 5);
        m_ready = 1'b1; idx = 0;
        for (int c = 0; c < 20 && idx < 5; c++) begin
            if (m_valid) begin
                check($sformatf("bp_order_%0d", idx), 32'(m_data), 32'(ram[idx]));
                $display("tx release word %0d data=%02h", idx, m_data);
                idx++;
            end
            step(); #4;
        end
        check("bp_count", 32'(idx), 5);
        step();

        // Test 5: random stream across pointer wrap, checked against the queue model.
        do_reset();
        step();
        wp = '0; written = 0; received = 0;
        for (int c = 0; c < 3000 && received < 40; c++) begin
            m_ready = ($urandom_range(0, 3) != 0);
            if (written < 40 && $urandom_range(0, 1) == 1) begin
                st = $urandom_range(1, 3);
                if (st > 40 - written) st = 40 - written;
                if (st > DEPTH - q.size()) st = DEPTH - q.size();
                for (int j = 0; j < st; j++) begin
                    ram[wp[AW-1:0]] = 8'($urandom);
                    q.push_back(ram[wp[AW-1:0]]);
                    wp = wp + 1'b1;
                    written++;
                end
                w_pt = wp;
            end
            #4;
            check("rand_level", 32'(level), 32'(q.size()));
            if (m_valid && m_ready) begin
                if (q.size() == 0) begin
                    check("rand_spurious_valid", 32'(m_valid), 0);
                end else begin
                    exp_d = q.pop_front();
                    check($sformatf("rand_data_%0d", received), 32'(m_data), 32'(exp_d));
                    $display("tx rand %0d data=%02h r_pt=%0d", received, m_data, r_pt);
                    received++;
                end
            end
            step();
        end
        check("rand_received", 32'(received), 40);

        // Test 6: a corrupt pointer distance sets err, err stays set, and reset clears it.
        do_reset();
        step();
        w_pt = 4'd9; m_ready = 1'b0;
        #4;
        check("err_before_edge", 32'(err), 0);
        step(); #4;
        check("err_set", 32'(err), 1);
        for (int k = 0; k < 5; k++) step();
        #4;
        check("err_sticky", 32'(err), 1);
        check("err_rcnt", 32'(rcnt), 7);
        rst = 1'b1; w_pt = '0;
        step(); #4;
        check("err_rst_clear", 32'(err), 0);
        check("err_rst_rpt", 32'(r_pt), 0);
        check("err_rst_valid", 32'(m_valid), 0);
        rst = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
